// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, debounce counter and press/hold FSM
// producing a clean level, edge/long/repeat pulses and a wrapping press counter.
module key_debounce #(
  parameter logic [31:0] DB_CNT         = 32'd1000000,
  parameter logic [31:0] LONG_CNT       = 32'd50000000,
  parameter logic [31:0] REPEAT_CNT     = 32'd10000000,
  parameter logic        KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       key_state,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic       key_repeat,
  output logic [7:0] press_cnt
);

  typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, LONG, REL_DB} state_t;

  // Released pin level, so the synchroniser comes out of reset reading "not pressed".
  localparam logic REL_LVL = KEY_ACTIVE_LOW;

  logic        s1, s2, pk;
  state_t      state, state_nxt;
  logic [31:0] db_cnt, db_nxt;
  logic [31:0] hold_cnt, hold_nxt;
  logic [31:0] rep_cnt, rep_nxt;
  logic        was_long, was_long_nxt;
  logic        kstate_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;
  logic [7:0]  pcnt_nxt;
  logic        hold_tick, rep_tick;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  assign pk = KEY_ACTIVE_LOW ? ~s2 : s2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      was_long    <= 1'b0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
      press_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= db_nxt;
      hold_cnt    <= hold_nxt;
      rep_cnt     <= rep_nxt;
      was_long    <= was_long_nxt;
      key_state   <= kstate_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
      key_repeat  <= repeat_nxt;
      press_cnt   <= pcnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    db_nxt       = db_cnt;
    hold_nxt     = hold_cnt;
    rep_nxt      = rep_cnt;
    was_long_nxt = was_long;
    kstate_nxt   = key_state;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    repeat_nxt   = 1'b0;
    pcnt_nxt     = press_cnt;
    hold_tick    = 1'b0;
    rep_tick     = 1'b0;

    case (state)
      IDLE: begin
        if (pk) begin
          state_nxt = PRESS_DB;
          db_nxt    = 32'd1;
        end
      end
      PRESS_DB: begin
        if (!pk) begin
          state_nxt = IDLE;
          db_nxt    = '0;
        end else if (db_cnt == DB_CNT - 32'd1) begin
          state_nxt    = HELD;
          db_nxt       = '0;
          hold_nxt     = '0;
          was_long_nxt = 1'b0;
          press_nxt    = 1'b1;
          kstate_nxt   = 1'b1;
          pcnt_nxt     = press_cnt + 8'd1;
        end else begin
          db_nxt = db_cnt + 32'd1;
        end
      end
      HELD: begin
        if (!pk) begin
          state_nxt    = REL_DB;
          db_nxt       = 32'd1;
          was_long_nxt = 1'b0;
        end else begin
          hold_tick = 1'b1;
        end
      end
      LONG: begin
        if (!pk) begin
          state_nxt    = REL_DB;
          db_nxt       = 32'd1;
          was_long_nxt = 1'b1;
        end else begin
          rep_tick = 1'b1;
        end
      end
      REL_DB: begin
        if (!pk) begin
          if (db_cnt == DB_CNT - 32'd1) begin
            state_nxt   = IDLE;
            db_nxt      = '0;
            hold_nxt    = '0;
            rep_nxt     = '0;
            release_nxt = 1'b1;
            kstate_nxt  = 1'b0;
          end else begin
            db_nxt = db_cnt + 32'd1;
          end
        end else begin
          // Bounce rejected: the returning edge counts as an ordinary held cycle.
          db_nxt    = '0;
          hold_tick = !was_long;
          rep_tick  = was_long;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (hold_tick) begin
      if (hold_cnt == LONG_CNT - 32'd1) begin
        state_nxt = LONG;
        rep_nxt   = '0;
        long_nxt  = 1'b1;
      end else begin
        state_nxt = HELD;
        hold_nxt  = hold_cnt + 32'd1;
      end
    end

    if (rep_tick) begin
      state_nxt = LONG;
      if (rep_cnt == REPEAT_CNT - 32'd1) begin
        rep_nxt    = '0;
        repeat_nxt = 1'b1;
      end else begin
        rep_nxt = rep_cnt + 32'd1;
      end
    end
  end

endmodule
